prog_loader: RTL and testbench



---
 rtl/prog_loader_pkg.sv | 16 +
 rtl/prog_loader.sv | 142 ++++++++++++++
 tb/tb_prog_loader.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared types and defaults for the serial program loader.
//   state_t        framing state machine encoding
//   SYNC_BYTE_DEF  default packet start marker
//   DEPTH_DEF      default program memory depth in words
//   ADDR_W/WORD_W  program memory address / instruction word widths
package prog_loader_pkg;
  localparam int         ADDR_W        = 11;
  localparam int         WORD_W        = 14;
  localparam int         CNT_W         = 12;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         DEPTH_DEF     = 2048;

  typedef enum logic [2:0] {
    S_IDLE, S_CNT_LO, S_CNT_HI, S_DATA_LO, S_DATA_HI, S_CHECK, S_DONE, S_ERR
  } state_t;
endpackage

// File: rtl/prog_loader.sv
// prog_loader: frames UART bytes (sync, count lo/hi, data lo/hi pairs,
// checksum) into 14-bit program memory writes and holds the core in reset
// until a packet has been accepted intact.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rx_data/rx_valid  received byte and its one-cycle strobe
//   pm_we/pm_addr/pm_wdata  program memory write port (one pulse per word)
//   core_rst          high while the CPU must stay in reset
//   load_done/load_err  sticky outcome of the last packet
//   words_loaded      words written by the current/last packet
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         DEPTH     = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              pm_we,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [WORD_W-1:0] pm_wdata,
  output logic              core_rst,
  output logic              load_done,
  output logic              load_err,
  output logic [CNT_W-1:0]  words_loaded
);
  localparam logic [15:0] DEPTH16 = 16'(DEPTH);

  state_t            r_state;
  logic [7:0]        r_cnt_lo;
  logic [7:0]        r_data_lo;
  logic [7:0]        r_sum;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_words;
  logic [ADDR_W-1:0] r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic              r_we;
  logic              r_core_rst;
  logic              r_done;
  logic              r_err;

  logic [15:0]      w_count;
  logic [7:0]       w_sum_nxt;
  logic [CNT_W-1:0] w_words_nxt;

  assign w_count     = {rx_data, r_cnt_lo};
  assign w_sum_nxt   = r_sum + rx_data;
  assign w_words_nxt = r_words + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt_lo   <= '0;
      r_data_lo  <= '0;
      r_sum      <= '0;
      r_count    <= '0;
      r_words    <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_core_rst <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_we <= 1'b0;
      // Address advances the edge after the write pulse so pm_addr stays
      // stable for the whole pm_we cycle.
      if (r_we) r_addr <= r_addr + ADDR_W'(1);
      if (rx_valid) begin
        case (r_state)
          S_IDLE, S_DONE, S_ERR: begin
            if (rx_data == SYNC_BYTE) begin
              r_state    <= S_CNT_LO;
              r_done     <= 1'b0;
              r_err      <= 1'b0;
              r_words    <= '0;
              r_sum      <= '0;
              r_addr     <= '0;
              r_core_rst <= 1'b1;
            end
          end
          S_CNT_LO: begin
            r_cnt_lo <= rx_data;
            r_sum    <= w_sum_nxt;
            r_state  <= S_CNT_HI;
          end
          S_CNT_HI: begin
            r_sum   <= w_sum_nxt;
            r_count <= w_count[CNT_W-1:0];
            if (w_count > DEPTH16) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end else if (w_count == 16'd0) begin
              r_state <= S_CHECK;
            end else begin
              r_state <= S_DATA_LO;
            end
          end
          S_DATA_LO: begin
            r_data_lo <= rx_data;
            r_sum     <= w_sum_nxt;
            r_state   <= S_DATA_HI;
          end
          S_DATA_HI: begin
            r_sum <= w_sum_nxt;
            // Top two bits must be clear for a 14-bit instruction word.
            if (rx_data[7:6] != 2'b00) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end else begin
              r_we    <= 1'b1;
              r_wdata <= {rx_data[5:0], r_data_lo};
              r_words <= w_words_nxt;
              r_state <= (w_words_nxt == r_count) ? S_CHECK : S_DATA_LO;
            end
          end
          S_CHECK: begin
            if (w_sum_nxt == 8'd0) begin
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_core_rst <= 1'b0;
            end else begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign pm_we        = r_we;
  assign pm_addr      = r_addr;
  assign pm_wdata     = r_wdata;
  assign core_rst     = r_core_rst;
  assign load_done    = r_done;
  assign load_err     = r_err;
  assign words_loaded = r_words;
endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: a packet-level parser predicts the write sequence
// and final flags; a monitor checks every pm_we pulse against it.
module tb_prog_loader;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        pm_we;
  logic [10:0] pm_addr;
  logic [13:0] pm_wdata;
  logic        core_rst;
  logic        load_done;
  logic        load_err;
  logic [11:0] words_loaded;

  prog_loader dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .pm_we(pm_we), .pm_addr(pm_addr), .pm_wdata(pm_wdata),
    .core_rst(core_rst), .load_done(load_done), .load_err(load_err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] pkt[$];
  int exp_addr[$];
  int exp_data[$];
  int exp_done, exp_err, exp_core, exp_wl;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Packet-level reference: skip to sync, then parse count, words, checksum.
  task automatic model_pkt();
    int i, cnt, s, a;
    logic [7:0] lo, hi;
    i = 0;
    while (i < pkt.size() && pkt[i] != 8'hA5) i++;
    if (i >= pkt.size()) return;
    i++;
    exp_done = 0; exp_err = 0; exp_core = 1; exp_wl = 0; a = 0;
    cnt = int'({pkt[i+1], pkt[i]});
    s = int'(pkt[i]) + int'(pkt[i+1]);
    i += 2;
    if (cnt > 2048) begin exp_err = 1; return; end
    for (int n = 0; n < cnt; n++) begin
      lo = pkt[i]; hi = pkt[i+1]; i += 2;
      s = s + int'(lo) + int'(hi);
      if (hi[7:6] != 2'b00) begin exp_err = 1; return; end
      exp_addr.push_back(a);
      exp_data.push_back(int'({hi[5:0], lo}));
      a++; exp_wl++;
    end
    s = s + int'(pkt[i]);
    if ((s & 255) == 0) begin exp_done = 1; exp_core = 0; end
    else exp_err = 1;
  endtask

  // Drive pkt[from..to-1]; optional random idle cycles between bytes.
  // Returns at the falling edge after the last byte was sampled.
  task automatic send(input int from, input int to, input int maxgap);
    int g;
    for (int k = from; k < to; k++) begin
      g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      repeat (g) begin @(negedge clk); rx_valid = 1'b0; end
      @(negedge clk); rx_data = pkt[k]; rx_valid = 1'b1;
    end
    @(negedge clk); rx_valid = 1'b0;
  endtask

  task automatic post(input string tag);
    chk({tag, "_done"}, int'(load_done), exp_done);
    chk({tag, "_err"},  int'(load_err),  exp_err);
    chk({tag, "_core"}, int'(core_rst),  exp_core);
    chk({tag, "_wl"},   int'(words_loaded), exp_wl);
    repeat (2) @(negedge clk);
    chk({tag, "_pending_writes"}, exp_addr.size(), 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_we"},    int'(pm_we), 0);
    chk({tag, "_addr"},  int'(pm_addr), 0);
    chk({tag, "_wdata"}, int'(pm_wdata), 0);
    chk({tag, "_core"},  int'(core_rst), 1);
    chk({tag, "_done"},  int'(load_done), 0);
    chk({tag, "_err"},   int'(load_err), 0);
    chk({tag, "_wl"},    int'(words_loaded), 0);
  endtask

  task automatic wr_mon();
    forever begin
      @(negedge clk);
      if (pm_we) begin
        if (exp_addr.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write: got addr %0h data %0h want no write",
                   pm_addr, pm_wdata);
        end else begin
          chk("wr_addr", int'(pm_addr), exp_addr.pop_front());
          chk("wr_data", int'(pm_wdata), exp_data.pop_front());
        end
      end
    end
  endtask

  initial begin
    int s, d;
    logic [7:0] lo, hi;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    exp_done = 0; exp_err = 0; exp_core = 1; exp_wl = 0;
    fork wr_mon(); join_none
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;

    // Garbage before any sync is ignored.
    pkt = '{8'h00, 8'hFF, 8'h12};
    model_pkt(); send(0, 3, 0); post("garbage");

    // Good two-word packet; checksum 0xBC makes 02+FF+3F+03+01+BC == 0 mod 256.
    pkt = '{8'hA5, 8'h02, 8'h00, 8'hFF, 8'h3F, 8'h03, 8'h01, 8'hBC};
    model_pkt();
    chk("model_w0", exp_data[0], 14'h3FFF);
    chk("model_w1", exp_data[1], 14'h0103);
    chk("model_done", exp_done, 1);
    send(0, 5, 0);
    // One cycle after the first DATA_HI byte: write pulse, count already 1.
    chk("t1_we_pulse", int'(pm_we), 1);
    chk("t1_wl_early", int'(words_loaded), 1);
    send(5, 8, 0);
    chk("t1_wl_lit", int'(words_loaded), 2);
    chk("t1_core_lit", int'(core_rst), 0);
    post("good");

    // Second sync after DONE, then the same packet with checksum off by one.
    pkt = '{8'hA5, 8'h02, 8'h00, 8'hFF, 8'h3F, 8'h03, 8'h01, 8'hBD};
    model_pkt();
    send(0, 1, 0);
    chk("resync_core", int'(core_rst), 1);
    chk("resync_done", int'(load_done), 0);
    chk("resync_wl", int'(words_loaded), 0);
    chk("resync_addr", int'(pm_addr), 0);
    send(1, 8, 0);
    chk("badsum_err_lit", int'(load_err), 1);
    post("badsum");

    // Count 2049: rejected right after the count.
    pkt = '{8'hA5, 8'h01, 8'h08};
    model_pkt(); send(0, 3, 0); post("cnt2049");

    // Count 0 with checksum 0.
    pkt = '{8'hA5, 8'h00, 8'h00, 8'h00};
    model_pkt(); send(0, 4, 1); post("cnt0");

    // Illegal high byte 0x40: error, no write for that word.
    pkt = '{8'hA5, 8'h01, 8'h00, 8'h34, 8'h40};
    model_pkt(); send(0, 5, 0); post("badhi");

    // Full-depth packet, back-to-back bytes.
    pkt = '{8'hA5, 8'h00, 8'h08};
    s = 8;
    for (int k = 0; k < 2048; k++) begin
      d = (k * 37 + 5) & 16'h3FFF;
      lo = d[7:0]; hi = {2'b00, d[13:8]};
      pkt.push_back(lo); pkt.push_back(hi);
      s = s + int'(lo) + int'(hi);
    end
    pkt.push_back(8'((256 - (s & 255)) & 255));
    model_pkt();
    chk("model_full_n", exp_addr.size(), 2048);
    chk("model_full_last", exp_addr[2047], 11'h7FF);
    send(0, pkt.size(), 0);
    chk("full_wl_lit", int'(words_loaded), 12'h800);
    post("full");

    // Reset while waiting in DATA_HI.
    pkt = '{8'hA5, 8'h02, 8'h00, 8'hFF};
    send(0, 4, 0);
    @(negedge clk); rx_data = 8'h3F; rx_valid = 1'b1; rst = 1'b1;
    @(negedge clk); rx_valid = 1'b0; rst = 1'b0;
    chk_reset_vals("midrst");
    exp_done = 0; exp_err = 0; exp_core = 1; exp_wl = 0;

    // Fresh packet after reset, with random gaps: loads from address 0.
    pkt = '{8'hA5, 8'h01, 8'h00, 8'h34, 8'h12, 8'hB9};
    model_pkt();
    chk("model_after_rst_addr", exp_addr[0], 0);
    send(0, 6, 2);
    post("afterrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
